// File: rtl/fib_sequencer_if.sv
// Command and term-stream bundle for fib_sequencer.
// The slave modport is the sequencer's view; master is the command source / consumer.
interface fib_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) ();
    logic             start;
    logic [CNT_W-1:0] n_terms;
    logic             abort;
    logic             busy;
    logic             done;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_index;
    logic             out_last;
    logic             overflow;

    modport slave (
        input  start, n_terms, abort, out_ready,
        output busy, done, out_valid, out_data, out_index, out_last, overflow
    );

    modport master (
        output start, n_terms, abort, out_ready,
        input  busy, done, out_valid, out_data, out_index, out_last, overflow
    );
endinterface

// File: rtl/fib_sequencer.sv
// Fibonacci term sequencer: on an accepted start it streams F(0)..F(N-1) over a
// valid/ready channel, pulses done at normal completion, supports abort and keeps
// a sticky overflow flag that rises once a wrapped term has been handed over.
module fib_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic           clock,
    input  logic           reset,
    fib_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] IDX_ONE = CNT_W'(1);

    state_t           state_q;
    logic [WIDTH-1:0] prev_q, curr_q;
    logic [CNT_W-1:0] idx_q, n_q;
    logic             prevTag_q, currTag_q;
    logic             overflow_q;

    logic [WIDTH-1:0] prev_d, curr_d;
    logic             prevTag_d, currTag_d;
    logic [WIDTH:0]   sum;
    logic             handshake;
    logic             isLast;

    assign handshake = (state_q == EMIT) && bus.out_ready;
    assign isLast    = (idx_q == (n_q - IDX_ONE));

    // Next pair of terms; each wrap tag remembers whether its term has ever wrapped
    always_comb begin
        sum       = {1'b0, prev_q} + {1'b0, curr_q};
        prev_d    = curr_q;
        curr_d    = sum[WIDTH-1:0];
        prevTag_d = currTag_q;
        currTag_d = sum[WIDTH] | prevTag_q | currTag_q;
    end

    // Sequencing FSM with the term registers and sticky overflow flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            curr_q     <= WIDTH'(1);
            idx_q      <= '0;
            n_q        <= '0;
            prevTag_q  <= 1'b0;
            currTag_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        n_q        <= bus.n_terms;
                        overflow_q <= 1'b0;
                        prev_q     <= '0;
                        curr_q     <= WIDTH'(1);
                        idx_q      <= '0;
                        prevTag_q  <= 1'b0;
                        currTag_q  <= 1'b0;
                        state_q    <= (bus.n_terms == '0) ? DONE : EMIT;
                    end
                end
                EMIT: begin
                    if (handshake && prevTag_q) begin
                        overflow_q <= 1'b1;
                    end
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else if (handshake) begin
                        if (isLast) begin
                            state_q <= DONE;
                        end else begin
                            prev_q    <= prev_d;
                            curr_q    <= curr_d;
                            prevTag_q <= prevTag_d;
                            currTag_q <= currTag_d;
                            idx_q     <= idx_q + IDX_ONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_data  = (state_q == EMIT) ? prev_q : '0;
    assign bus.out_index = (state_q == EMIT) ? idx_q : '0;
    assign bus.out_last  = (state_q == EMIT) && isLast;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// Randomized self-checking bench for fib_sequencer against a term table built
// from plain Fibonacci arithmetic.
module tb_fib_sequencer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic clock;
    logic reset;
    int   checkCount = 0;
    int   errorCount = 0;

    logic [63:0]     fibMod  [256];
    bit              exceeds [256];
    bit              readyPat[7] = '{1, 0, 0, 1, 1, 0, 1};

    fib_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) busIf ();

    fib_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (busIf)
    );

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".valid"}, 64'(busIf.out_valid), 0);
        checkOutput({tag, ".busy"},  64'(busIf.busy), 0);
        checkOutput({tag, ".done"},  64'(busIf.done), 0);
        checkOutput({tag, ".last"},  64'(busIf.out_last), 0);
        checkOutput({tag, ".data"},  64'(busIf.out_data), 0);
        checkOutput({tag, ".index"}, 64'(busIf.out_index), 0);
        checkOutput({tag, ".ovf"},   64'(busIf.overflow), 0);
    endtask

    // Issue a start and follow the stream; readyPct<0 uses readyPat, abortIdx>=0
    // stalls once at that index and then aborts.
    task automatic applyStimulus(input int n, input int readyPct, input int abortIdx, input bit randStart);
        int k = 0;
        int cyc = 0;
        int abortVisits = 0;
        bit ovExp = 0;
        bit rdy;
        bit aborted = 0;
        bit abortNow;
        @(posedge clock); #1;
        busIf.start = 1'b1;
        busIf.n_terms = CNT_W'(n);
        busIf.abort = 1'b0;
        busIf.out_ready = 1'b0;
        @(posedge clock); #1;
        busIf.start = 1'b0;
        if (n == 0) begin
            @(negedge clock);
            checkOutput("zero.valid", 64'(busIf.out_valid), 0);
            checkOutput("zero.done", 64'(busIf.done), 1);
            checkOutput("zero.busy", 64'(busIf.busy), 1);
            @(posedge clock); #1;
            @(negedge clock);
            checkOutput("zero.doneAfter", 64'(busIf.done), 0);
            checkOutput("zero.busyAfter", 64'(busIf.busy), 0);
            checkOutput("zero.validAfter", 64'(busIf.out_valid), 0);
            return;
        end
        while (k < n && cyc < 4000) begin
            if (readyPct < 0) rdy = (cyc < 7) ? readyPat[cyc] : 1'b1;
            else rdy = ($urandom_range(99) < readyPct);
            abortNow = 1'b0;
            if (k == abortIdx) begin
                if (abortVisits == 0) rdy = 1'b0;
                else abortNow = 1'b1;
                abortVisits++;
            end
            busIf.out_ready = rdy;
            busIf.abort = abortNow;
            if (randStart) begin
                busIf.start = 1'($urandom_range(1));
                busIf.n_terms = CNT_W'($urandom_range(255));
            end
            @(negedge clock);
            checkOutput("emit.valid", 64'(busIf.out_valid), 1);
            checkOutput("emit.data", 64'(busIf.out_data), fibMod[k]);
            checkOutput("emit.index", 64'(busIf.out_index), 64'(k));
            checkOutput("emit.last", 64'(busIf.out_last), 64'(k == n - 1));
            checkOutput("emit.busy", 64'(busIf.busy), 1);
            checkOutput("emit.done", 64'(busIf.done), 0);
            checkOutput("emit.ovf", 64'(busIf.overflow), 64'(ovExp));
            if (rdy) begin
                if (exceeds[k]) ovExp = 1'b1;
                k++;
            end
            cyc++;
            @(posedge clock); #1;
            if (abortNow) begin
                aborted = 1'b1;
                break;
            end
        end
        busIf.start = 1'b0;
        busIf.abort = 1'b0;
        busIf.out_ready = 1'b0;
        if (aborted) begin
            @(negedge clock);
            checkOutput("abort.valid", 64'(busIf.out_valid), 0);
            checkOutput("abort.done", 64'(busIf.done), 0);
            checkOutput("abort.busy", 64'(busIf.busy), 0);
            checkOutput("abort.ovf", 64'(busIf.overflow), 64'(ovExp));
            return;
        end
        checkOutput("seq.progress", 64'(k), 64'(n));
        @(negedge clock);
        checkOutput("end.done", 64'(busIf.done), 1);
        checkOutput("end.busy", 64'(busIf.busy), 1);
        checkOutput("end.valid", 64'(busIf.out_valid), 0);
        checkOutput("end.ovf", 64'(busIf.overflow), 64'(ovExp));
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("idle.done", 64'(busIf.done), 0);
        checkOutput("idle.busy", 64'(busIf.busy), 0);
        checkOutput("idle.ovfHeld", 64'(busIf.overflow), 64'(ovExp));
    endtask

    // Pull reset low mid-stream at index 3 and expect an immediate clear
    task automatic checkOutputAsyncReset();
        @(posedge clock); #1;
        busIf.start = 1'b1;
        busIf.n_terms = CNT_W'(10);
        busIf.out_ready = 1'b1;
        @(posedge clock); #1;
        busIf.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checkOutput("rst.data", 64'(busIf.out_data), fibMod[k]);
            checkOutput("rst.index", 64'(busIf.out_index), 64'(k));
            if (k < 3) begin
                @(posedge clock); #1;
            end
        end
        #1 reset = 1'b0;
        #1 checkAllZero("asyncRst");
        @(posedge clock); #1;
        checkAllZero("rstHeld");
        reset = 1'b1;
        busIf.out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] tv[256];
        logic [63:0] cap;
        cap = 64'h0000_0100_0000_0000;
        fibMod[0] = 0; fibMod[1] = 1;
        tv[0] = 0; tv[1] = 1;
        for (int i = 2; i < 256; i++) begin
            fibMod[i] = (fibMod[i-1] + fibMod[i-2]) & 64'hFFFF_FFFF;
            tv[i] = tv[i-1] + tv[i-2];
            if (tv[i] > cap) tv[i] = cap;
        end
        for (int i = 0; i < 256; i++) exceeds[i] = (tv[i] >= 64'h1_0000_0000);

        reset = 1'b0;
        busIf.start = 1'b0;
        busIf.n_terms = '0;
        busIf.abort = 1'b0;
        busIf.out_ready = 1'b0;
        #12;
        checkAllZero("reset");
        @(posedge clock); #1;
        reset = 1'b1;

        // Abort while idle must do nothing
        busIf.abort = 1'b1;
        @(negedge clock);
        @(posedge clock); #1;
        busIf.abort = 1'b0;
        @(negedge clock);
        checkOutput("idleAbort.busy", 64'(busIf.busy), 0);
        checkOutput("idleAbort.valid", 64'(busIf.out_valid), 0);

        $display("[TB] n=5 full rate");
        applyStimulus(5, 100, -1, 0);
        $display("[TB] n=4 ready pattern");
        applyStimulus(4, -1, -1, 0);
        $display("[TB] n=50 overflow");
        applyStimulus(50, 100, -1, 0);
        $display("[TB] n=3 after overflow");
        applyStimulus(3, 100, -1, 0);
        $display("[TB] n=0");
        applyStimulus(0, 100, -1, 0);
        $display("[TB] n=10 abort at index 2");
        applyStimulus(10, 100, 2, 0);
        applyStimulus(3, 100, -1, 0);
        $display("[TB] async reset mid-sequence");
        checkOutputAsyncReset();
        applyStimulus(6, 100, -1, 0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 16; r++) begin
            int n;
            int pct;
            int ab;
            n = $urandom_range(60, 0);
            pct = $urandom_range(100, 30);
            ab = ($urandom_range(3) == 0 && n > 0) ? $urandom_range(n - 1, 0) : -1;
            applyStimulus(n, pct, ab, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
